sdram_port_scheduler: RTL and testbench

SDRAM_PORT_SCHEDULER -- requirements
Module: sdram_port_scheduler

---
 rtl/sdram_ctrl_pkg.sv | 13 +
 rtl/sdram_port_scheduler_rr_pick.sv | 31 +++
 rtl/sdram_port_scheduler.sv | 120 ++++++++++++
 tb/tb_sdram_port_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared scheduler types: FSM state encoding and the width of the per-grant command counter.
package sdram_ctrl_pkg;

  localparam int QUOTA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN,
    ST_REFRESH
  } sched_state_t;

endpackage

// File: rtl/sdram_port_scheduler_rr_pick.sv
// Round-robin pick: first requester strictly after last_idx, wrapping PORTS-1 -> 0.
// Purely combinational; last_idx itself is considered last, so the previous owner has lowest priority.
module rr_pick #(
  parameter int PORTS = 3,
  parameter int ENC_W = $clog2(PORTS)
) (
  input  logic [ENC_W-1:0] last_idx,
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] onehot,
  output logic [ENC_W-1:0] idx,
  output logic             any
);

  logic [ENC_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int off = 1; off <= PORTS; off++) begin
      cand = ENC_W'((int'(last_idx) + off) % PORTS);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Grants the SDRAM controller to one port for up to QUOTA accepts, or to refresh; 1-cycle arbitration.
// Backpressure: ready_i gates accepts for the owner only; DRAIN waits on idle_i before re-arbitrating.
module sdram_port_scheduler
  import sdram_ctrl_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int QUOTA = 4,
  parameter int ENC_W = $clog2(PORTS)
) (
  input  logic             sdram_clk,
  input  logic             sdram_rst,
  input  logic [PORTS-1:0] req_i,
  input  logic             ready_i,
  input  logic             idle_i,
  input  logic             ref_req_i,
  input  logic             ref_done_i,
  output logic [PORTS-1:0] grant_o,
  output logic [ENC_W-1:0] grant_enc_o,
  output logic [PORTS-1:0] ready_o,
  output logic             ref_gnt_o
);

  sched_state_t       state_q, state_d;
  logic [PORTS-1:0]   grant_q, grant_d;
  logic [ENC_W-1:0]   enc_q, enc_d;
  logic               ref_gnt_q, ref_gnt_d;
  logic [QUOTA_W-1:0] count_q, count_d;

  logic [PORTS-1:0]   pick_onehot;
  logic [ENC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;

  rr_pick #(
    .PORTS (PORTS),
    .ENC_W (ENC_W)
  ) u_rr_pick (
    .last_idx (enc_q),
    .req      (req_i),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign accept = (state_q == ST_GRANT) && req_i[enc_q] && ready_i;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    enc_d     = enc_q;
    ref_gnt_d = ref_gnt_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        // Refresh is checked first so a pending refresh always beats port traffic.
        if (ref_req_i) begin
          state_d   = ST_REFRESH;
          ref_gnt_d = 1'b1;
        end else if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = pick_onehot;
          enc_d   = pick_idx;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          count_d = count_q + QUOTA_W'(1);
          if (count_q + QUOTA_W'(1) == QUOTA_W'(QUOTA)) begin
            state_d = ST_DRAIN;
            grant_d = '0;
          end
        end else if (!req_i[enc_q]) begin
          state_d = ST_DRAIN;
          grant_d = '0;
        end
      end
      ST_DRAIN: begin
        if (idle_i) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
      ST_REFRESH: begin
        if (ref_done_i) begin
          state_d   = ST_IDLE;
          ref_gnt_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        ref_gnt_d = 1'b0;
        count_d   = '0;
      end
    endcase
  end

  // Last-owner index resets to PORTS-1 so port 0 is the first winner.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      enc_q     <= ENC_W'(PORTS - 1);
      ref_gnt_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      enc_q     <= enc_d;
      ref_gnt_q <= ref_gnt_d;
      count_q   <= count_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_enc_o = enc_q;
  assign ref_gnt_o   = ref_gnt_q;
  assign ready_o     = grant_q & {PORTS{ready_i}};

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler (PORTS=3, QUOTA=4) plus a QUOTA=1 instance on shared inputs.
module tb_sdram_port_scheduler;

  logic       sdram_clk;
  logic       sdram_rst;
  logic [2:0] req_i;
  logic       ready_i;
  logic       idle_i;
  logic       ref_req_i;
  logic       ref_done_i;
  logic [2:0] grant_o;
  logic [1:0] grant_enc_o;
  logic [2:0] ready_o;
  logic       ref_gnt_o;

  logic [2:0] q1_grant;
  logic [1:0] q1_enc;
  logic [2:0] q1_ready;
  logic       q1_ref_gnt;

  int tests = 0;
  int fails = 0;

  sdram_port_scheduler #(.PORTS(3), .QUOTA(4)) dut (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .req_i       (req_i),
    .ready_i     (ready_i),
    .idle_i      (idle_i),
    .ref_req_i   (ref_req_i),
    .ref_done_i  (ref_done_i),
    .grant_o     (grant_o),
    .grant_enc_o (grant_enc_o),
    .ready_o     (ready_o),
    .ref_gnt_o   (ref_gnt_o)
  );

  sdram_port_scheduler #(.PORTS(3), .QUOTA(1)) dut_q1 (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .req_i       (req_i),
    .ready_i     (ready_i),
    .idle_i      (idle_i),
    .ref_req_i   (ref_req_i),
    .ref_done_i  (ref_done_i),
    .grant_o     (q1_grant),
    .grant_enc_o (q1_enc),
    .ready_o     (q1_ready),
    .ref_gnt_o   (q1_ref_gnt)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    sdram_rst  = 1'b1;
    req_i      = 3'b000;
    ready_i    = 1'b0;
    idle_i     = 1'b0;
    ref_req_i  = 1'b0;
    ref_done_i = 1'b0;
    step();
    step();
    chk("rst_grant",   8'(grant_o),     8'h00);
    chk("rst_enc",     8'(grant_enc_o), 8'h02);
    chk("rst_ref_gnt", 8'(ref_gnt_o),   8'h00);
    chk("rst_ready_o", 8'(ready_o),     8'h00);
    sdram_rst = 1'b0;

    // All ports requesting: 0,1,2,0 each for 4 accepts, DRAIN and IDLE between.
    req_i   = 3'b111;
    ready_i = 1'b1;
    idle_i  = 1'b1;
    step();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_g%0d_k%0d", g, k), 8'(grant_o), 8'(1 << (g % 3)));
        if (k == 0) begin
          chk($sformatf("rr_enc_g%0d", g), 8'(grant_enc_o), 8'(g % 3));
          chk($sformatf("rr_rdy_g%0d", g), 8'(ready_o), 8'(1 << (g % 3)));
        end
        if (g == 0 && k == 0) chk("q1_grant0", 8'(q1_grant), 8'h01);
        if (g == 0 && k == 1) chk("q1_drain",  8'(q1_grant), 8'h00);
        step();
      end
      chk($sformatf("rr_drain_g%0d", g), 8'(grant_o), 8'h00);
      step();
      chk($sformatf("rr_idle_g%0d", g), 8'(grant_o), 8'h00);
      step();
    end
    chk("rr_fifth_port1", 8'(grant_o), 8'h02);
    req_i = 3'b000;
    step();
    step();
    step();
    chk("idle_nogrant", 8'(grant_o),     8'h00);
    chk("idle_enc_hold", 8'(grant_enc_o), 8'h01);

    // Single requester on port 2, drops after 2 accepts; DRAIN waits for idle_i.
    req_i   = 3'b100;
    ready_i = 1'b0;
    idle_i  = 1'b0;
    step();
    chk("p2_grant",   8'(grant_o),     8'h04);
    chk("p2_enc",     8'(grant_enc_o), 8'h02);
    chk("p2_rdy_off", 8'(ready_o),     8'h00);
    ready_i = 1'b1;
    #1;
    chk("p2_rdy_on", 8'(ready_o), 8'h04);
    step();
    step();
    chk("p2_after2", 8'(grant_o), 8'h04);
    req_i = 3'b000;
    step();
    chk("p2_drain", 8'(grant_o), 8'h00);
    req_i = 3'b001;
    step();
    chk("p2_drain_hold1", 8'(grant_o), 8'h00);
    step();
    chk("p2_drain_hold2", 8'(grant_o), 8'h00);
    idle_i = 1'b1;
    step();
    chk("p2_to_idle", 8'(grant_o), 8'h00);
    step();
    chk("p0_after_p2", 8'(grant_o), 8'h01);

    // Refresh raised during port1 grant: quota completes, then REFRESH.
    req_i = 3'b000;
    step();
    step();
    req_i = 3'b010;
    step();
    chk("p1_grant", 8'(grant_o),     8'h02);
    chk("p1_enc",   8'(grant_enc_o), 8'h01);
    ref_req_i = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("ref_wait_k%0d", k), 8'(grant_o), 8'h02);
      chk($sformatf("ref_wait_gnt%0d", k), 8'(ref_gnt_o), 8'h00);
    end
    step();
    chk("ref_drain", 8'(grant_o), 8'h00);
    step();
    chk("ref_idle_gnt", 8'(ref_gnt_o), 8'h00);
    step();
    chk("ref_on",       8'(ref_gnt_o), 8'h01);
    chk("ref_on_grant", 8'(grant_o),   8'h00);
    ref_req_i = 1'b0;
    step();
    chk("ref_hold_nodone", 8'(ref_gnt_o), 8'h01);
    ref_done_i = 1'b1;
    step();
    ref_done_i = 1'b0;
    chk("ref_done_off",   8'(ref_gnt_o), 8'h00);
    chk("ref_done_idle",  8'(grant_o),   8'h00);
    step();
    chk("ref_then_p1", 8'(grant_o), 8'h02);

    // Refresh and requests together in IDLE: refresh first, then round-robin.
    req_i = 3'b000;
    step();
    step();
    ref_req_i = 1'b1;
    req_i     = 3'b011;
    step();
    chk("both_ref",   8'(ref_gnt_o), 8'h01);
    chk("both_nogrt", 8'(grant_o),   8'h00);
    ref_done_i = 1'b1;
    ref_req_i  = 1'b0;
    step();
    ref_done_i = 1'b0;
    chk("both_idle", 8'(ref_gnt_o), 8'h00);
    step();
    chk("both_p0",     8'(grant_o),     8'h01);
    chk("both_p0_enc", 8'(grant_enc_o), 8'h00);

    // Asynchronous reset in the middle of a grant.
    step();
    step();
    chk("mid_grant", 8'(grant_o), 8'h01);
    sdram_rst = 1'b1;
    #1;
    chk("arst_grant",   8'(grant_o),     8'h00);
    chk("arst_enc",     8'(grant_enc_o), 8'h02);
    chk("arst_ref_gnt", 8'(ref_gnt_o),   8'h00);
    step();
    step();
    sdram_rst = 1'b0;
    step();
    chk("post_rst_p0", 8'(grant_o), 8'h01);

    // ready_i with no owner is ignored; next grant still gets a full quota.
    req_i = 3'b000;
    step();
    step();
    ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("noown_rdy%0d", k), 8'(ready_o), 8'h00);
      chk($sformatf("noown_gnt%0d", k), 8'(grant_o), 8'h00);
    end
    req_i = 3'b010;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_quota_k%0d", k), 8'(grant_o), 8'h02);
      step();
    end
    chk("full_quota_end", 8'(grant_o), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
